// File: rtl/shift_flag_stage.sv
// shift_flag_stage: registered stage after the ALU shifter.
// Each accepted operation is tagged with N/Z/C/V flags. The result and its
// flags are held in a 2-entry skid buffer (main + skid) on their way to
// writeback. A wrapping counter tracks completed output handshakes.
module shift_flag_stage #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_operand,
    input  logic [SHAMT_W-1:0] in_amount,
    input  logic [2:0]         in_type,
    input  logic [WIDTH-1:0]   in_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [3:0]         out_flags,
    output logic [15:0]        op_count
);

    localparam logic [2:0] T_LSL = 3'b000;
    localparam logic [2:0] T_LSR = 3'b001;
    localparam logic [2:0] T_ASL = 3'b010;
    localparam logic [2:0] T_ASR = 3'b011;
    localparam logic [2:0] T_ROL = 3'b100;
    localparam logic [2:0] T_ROR = 3'b101;

    // Flags {N,Z,C,V} for one operation. C is the last bit shifted out of the
    // operand, which depends only on the direction; a zero shift moves no bit
    // out, so C is 0 there. The shifter result is trusted, never recomputed.
    function automatic logic [3:0] calc_flags(
        input logic [WIDTH-1:0]   operand,
        input logic [SHAMT_W-1:0] amount,
        input logic [2:0]         typ,
        input logic [WIDTH-1:0]   result
    );
        logic             n_f;
        logic             z_f;
        logic             c_f;
        logic             v_f;
        logic [SHAMT_W:0] left_idx;
        n_f      = result[WIDTH-1];
        z_f      = (result == '0);
        c_f      = 1'b0;
        v_f      = 1'b0;
        // Left shifts lose operand[WIDTH-n]; for n in 1..WIDTH-1 it fits SHAMT_W bits.
        left_idx = (SHAMT_W + 1)'(WIDTH) - {1'b0, amount};
        if (amount != '0) begin
            case (typ)
                T_LSL, T_ASL, T_ROL: c_f = operand[left_idx[SHAMT_W-1:0]];
                T_LSR, T_ASR, T_ROR: c_f = operand[amount - SHAMT_W'(1)];
                default:             c_f = 1'b0;
            endcase
        end
        if (typ == T_ASL) begin
            v_f = operand[WIDTH-1] ^ result[WIDTH-1];
        end
        return {n_f, z_f, c_f, v_f};
    endfunction

    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] main_res_q, main_res_d;
    logic [3:0]       main_flg_q, main_flg_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_res_q, skid_res_d;
    logic [3:0]       skid_flg_q, skid_flg_d;
    logic [15:0]      cnt_q, cnt_d;

    logic       accept;
    logic       drain;
    logic [3:0] new_flg;

    // in_ready comes straight from the skid flop, so out_ready never reaches it
    // combinationally.
    assign in_ready   = ~skid_vld_q;
    assign out_valid  = main_vld_q;
    assign out_result = main_res_q;
    assign out_flags  = main_flg_q;
    assign op_count   = cnt_q;

    assign accept  = in_valid & in_ready;
    assign drain   = main_vld_q & out_ready;
    assign new_flg = calc_flags(in_operand, in_amount, in_type, in_result);

    // Next-state for main/skid entries and the handshake counter.
    always_comb begin
        main_vld_d = main_vld_q;
        main_res_d = main_res_q;
        main_flg_d = main_flg_q;
        skid_vld_d = skid_vld_q;
        skid_res_d = skid_res_q;
        skid_flg_d = skid_flg_q;
        cnt_d      = cnt_q;

        if (drain) begin
            cnt_d = cnt_q + 16'd1;
        end

        if (skid_vld_q) begin
            // Input is blocked; a drain promotes the skid entry into main.
            if (drain) begin
                main_res_d = skid_res_q;
                main_flg_d = skid_flg_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q || drain) begin
                // Main is free or leaving this cycle: new entry replaces it.
                main_res_d = in_result;
                main_flg_d = new_flg;
                main_vld_d = 1'b1;
            end else begin
                // Main is stalled: park the new entry in skid.
                skid_res_d = in_result;
                skid_flg_d = new_flg;
                skid_vld_d = 1'b1;
            end
        end else if (drain) begin
            main_vld_d = 1'b0;
        end
    end

    // ---- stage register: main/skid entries and op counter ----
    // Payload is reset too so the output reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_res_q <= '0;
            main_flg_q <= '0;
            skid_vld_q <= 1'b0;
            skid_res_q <= '0;
            skid_flg_q <= '0;
            cnt_q      <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_res_q <= main_res_d;
            main_flg_q <= main_flg_d;
            skid_vld_q <= skid_vld_d;
            skid_res_q <= skid_res_d;
            skid_flg_q <= skid_flg_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
